// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard control: load-use / branch-operand stalls, taken-branch squash,
// multi-cycle data-memory freeze FSM. Define HAZARD_PERF_CNT_EN to build the stall counter.
module hazard_ctrl_unit #(
    parameter int REGISTER_BITS = 5,
    parameter int MEM_LAT       = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [REGISTER_BITS-1:0] id_rs,
    input  logic [REGISTER_BITS-1:0] id_rt,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic                     id_branch,
    input  logic                     branch_taken,
    input  logic                     ex_valid,
    input  logic                     ex_memread,
    input  logic                     ex_regwrite,
    input  logic [REGISTER_BITS-1:0] ex_dst,
    input  logic                     mem_valid,
    input  logic                     mem_memread,
    input  logic [REGISTER_BITS-1:0] mem_dst,
    output logic                     hold_pc,
    output logic                     hold_ifid,
    output logic                     flush_idex,
    output logic                     flush_ifid,
    output logic                     freeze_back,
    output logic                     flush_memwb,
    output logic [CNT_WIDTH-1:0]     stall_count
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam bit         LAT_EN = (MEM_LAT > 0);
    localparam logic [3:0] LAT_M1 = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       freeze;
    logic       rs_ex, rt_ex, rs_mem, rt_mem;
    logic       load_use, br_ex, br_mem, data_stall;

    // Register 0 is hard-wired, so it can never carry a dependency.
    function automatic logic src_hit(
        input logic                     valid,
        input logic                     uses,
        input logic [REGISTER_BITS-1:0] src,
        input logic [REGISTER_BITS-1:0] dst,
        input logic                     dst_valid
    );
        return valid & uses & (src != '0) & (src == dst) & dst_valid;
    endfunction

    assign rs_ex  = src_hit(id_valid, id_uses_rs, id_rs, ex_dst, ex_valid);
    assign rt_ex  = src_hit(id_valid, id_uses_rt, id_rt, ex_dst, ex_valid);
    assign rs_mem = src_hit(id_valid, id_uses_rs, id_rs, mem_dst, mem_valid);
    assign rt_mem = src_hit(id_valid, id_uses_rt, id_rt, mem_dst, mem_valid);

    // Branches compare in ID with no EX->ID forward path, so any EX producer stalls them.
    assign load_use   = ex_memread & (rs_ex | rt_ex);
    assign br_ex      = id_branch & ex_regwrite & ~ex_memread & (rs_ex | rt_ex);
    assign br_mem     = id_branch & mem_memread & (rs_mem | rt_mem);
    assign data_stall = load_use | br_ex | br_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // WAIT is only entered from IDLE, so the release cycle never re-triggers on the same load.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        freeze     = 1'b0;
        case (state)
            IDLE: begin
                if (LAT_EN && mem_valid && mem_memread) begin
                    freeze     = 1'b1;
                    cnt_next   = LAT_M1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    freeze   = 1'b1;
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are gated by rst_n so the pipeline sees no control activity during reset.
    always_comb begin
        hold_pc     = rst_n & (freeze | data_stall);
        hold_ifid   = rst_n & (freeze | data_stall);
        flush_idex  = rst_n & data_stall & ~freeze;
        flush_ifid  = rst_n & id_valid & id_branch & branch_taken & ~data_stall & ~freeze;
        freeze_back = rst_n & freeze;
        flush_memwb = rst_n & freeze;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (hold_pc && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed scenarios plus random traffic
// checked against a time-based reference model of the hazard rules.
module tb_hazard_ctrl_unit;

    localparam int TB_LAT = 2;
    localparam int TB_CW  = 4;
    localparam int CNT_MAX = (1 << TB_CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic       id_valid;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       branch;
        logic       taken;
        logic       ex_valid;
        logic       ex_memread;
        logic       ex_regwrite;
        logic [4:0] ex_dst;
        logic       mem_valid;
        logic       mem_memread;
        logic [4:0] mem_dst;
    } stim_t;

    typedef struct packed {
        logic [5:0]       f;
        logic [TB_CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid = 0, id_uses_rs = 0, id_uses_rt = 0, id_branch = 0, branch_taken = 0;
    logic ex_valid = 0, ex_memread = 0, ex_regwrite = 0, mem_valid = 0, mem_memread = 0;
    logic [4:0] id_rs = 0, id_rt = 0, ex_dst = 0, mem_dst = 0;
    logic hold_pc, hold_ifid, flush_idex, flush_ifid, freeze_back, flush_memwb;
    logic [TB_CW-1:0] stall_count;

    hazard_ctrl_unit #(.REGISTER_BITS(5), .MEM_LAT(TB_LAT), .CNT_WIDTH(TB_CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
        .branch_taken(branch_taken), .ex_valid(ex_valid), .ex_memread(ex_memread),
        .ex_regwrite(ex_regwrite), .ex_dst(ex_dst), .mem_valid(mem_valid),
        .mem_memread(mem_memread), .mem_dst(mem_dst), .hold_pc(hold_pc),
        .hold_ifid(hold_ifid), .flush_idex(flush_idex), .flush_ifid(flush_ifid),
        .freeze_back(freeze_back), .flush_memwb(flush_memwb), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a load's freeze window is measured in cycles since it was accepted.
    int cyc = 0;
    int load_start = -1;
    int model_cnt = 0;

    function automatic bit depends(input stim_t s, input logic [4:0] dst);
        return s.id_valid && (dst != 5'd0) &&
               ((s.uses_rs && s.id_rs == dst) || (s.uses_rt && s.id_rt == dst));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("hold_pc",     hold_pc,     e.f[5]);
            check("hold_ifid",   hold_ifid,   e.f[4]);
            check("flush_idex",  flush_idex,  e.f[3]);
            check("flush_ifid",  flush_ifid,  e.f[2]);
            check("freeze_back", freeze_back, e.f[1]);
            check("flush_memwb", flush_memwb, e.f[0]);
            check("stall_count", stall_count, e.cnt);
        end
    end

    task automatic apply(input stim_t s, input logic rst_val);
        exp_t e;
        bit   stall, frz, starting;
        int   age;
        @(posedge clk);
        #1;
        rst_n = rst_val;
        id_valid = s.id_valid; id_rs = s.id_rs; id_rt = s.id_rt;
        id_uses_rs = s.uses_rs; id_uses_rt = s.uses_rt;
        id_branch = s.branch; branch_taken = s.taken;
        ex_valid = s.ex_valid; ex_memread = s.ex_memread; ex_regwrite = s.ex_regwrite;
        ex_dst = s.ex_dst; mem_valid = s.mem_valid; mem_memread = s.mem_memread;
        mem_dst = s.mem_dst;
        if (!rst_val) begin
            load_start = -1;
            model_cnt  = 0;
            e = '0;
            exp_q.push_back(e);
            cyc++;
            return;
        end
        stall = (s.ex_valid && s.ex_memread && depends(s, s.ex_dst)) ||
                (s.branch && s.ex_valid && s.ex_regwrite && !s.ex_memread && depends(s, s.ex_dst)) ||
                (s.branch && s.mem_valid && s.mem_memread && depends(s, s.mem_dst));
        starting = 0;
        age = 0;
        if (load_start < 0) begin
            starting = (TB_LAT > 0) && s.mem_valid && s.mem_memread;
            frz = starting;
        end else begin
            age = cyc - load_start;
            frz = (age < TB_LAT);
        end
        e.f = {frz | stall, frz | stall, stall & !frz,
               s.id_valid & s.branch & s.taken & !stall & !frz, frz, frz};
        e.cnt = PERF ? TB_CW'(model_cnt) : '0;
        exp_q.push_back(e);
        if (starting) load_start = cyc;
        else if (load_start >= 0 && age == TB_LAT) load_start = -1;
        if ((frz || stall) && model_cnt < CNT_MAX) model_cnt++;
        cyc++;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.id_valid    = ($urandom_range(0, 7) != 0);
        s.id_rs       = 5'($urandom_range(0, 3));
        s.id_rt       = 5'($urandom_range(0, 3));
        s.uses_rs     = 1'($urandom);
        s.uses_rt     = 1'($urandom);
        s.branch      = ($urandom_range(0, 2) == 0);
        s.taken       = 1'($urandom);
        s.ex_valid    = ($urandom_range(0, 3) != 0);
        s.ex_memread  = ($urandom_range(0, 2) == 0);
        s.ex_regwrite = 1'($urandom);
        s.ex_dst      = 5'($urandom_range(0, 3));
        s.mem_valid   = ($urandom_range(0, 3) != 0);
        s.mem_memread = ($urandom_range(0, 4) == 0);
        s.mem_dst     = 5'($urandom_range(0, 3));
        return s;
    endfunction

    initial begin
        stim_t nop, s;
        nop = '0;

        apply(nop, 1'b0);
        apply(nop, 1'b0);
        apply(nop, 1'b1);

        // Load-use on rs, then the load moves on to MEM.
        s = nop;
        s.id_valid = 1; s.id_rs = 5'd8; s.uses_rs = 1;
        s.ex_valid = 1; s.ex_memread = 1; s.ex_regwrite = 1; s.ex_dst = 5'd8;
        apply(s, 1'b1);
        s.ex_valid = 0; s.ex_memread = 0; s.ex_regwrite = 0;
        apply(s, 1'b1);
        repeat (3) apply(nop, 1'b1);

        // Register zero and unused-source cases never stall.
        s = nop;
        s.id_valid = 1; s.uses_rs = 1;
        s.ex_valid = 1; s.ex_memread = 1; s.ex_regwrite = 1; s.ex_dst = 5'd0;
        apply(s, 1'b1);
        s.uses_rs = 0; s.id_rs = 5'd8; s.ex_dst = 5'd8;
        apply(s, 1'b1);

        // Branch operand from EX ALU result, then from a load in MEM.
        s = nop;
        s.id_valid = 1; s.branch = 1; s.id_rt = 5'd9; s.uses_rt = 1;
        s.ex_valid = 1; s.ex_regwrite = 1; s.ex_dst = 5'd9;
        apply(s, 1'b1);
        s.ex_valid = 0; s.ex_regwrite = 0;
        s.mem_valid = 1; s.mem_memread = 1; s.mem_dst = 5'd9;
        apply(s, 1'b1);
        s = nop; s.mem_valid = 1; s.mem_memread = 1; s.mem_dst = 5'd9;
        repeat (2) apply(s, 1'b1);
        repeat (2) apply(nop, 1'b1);

        // Back-to-back loads in MEM.
        s = nop; s.mem_valid = 1; s.mem_memread = 1; s.mem_dst = 5'd3;
        repeat (6) apply(s, 1'b1);
        apply(nop, 1'b1);

        // Taken branch held off by freeze, then squashes on release.
        s = nop; s.id_valid = 1; s.branch = 1; s.taken = 1;
        s.mem_valid = 1; s.mem_memread = 1; s.mem_dst = 5'd4;
        repeat (3) apply(s, 1'b1);
        s.mem_valid = 0; s.mem_memread = 0;
        apply(s, 1'b1);
        // Data stall wins over a taken branch.
        s.id_rt = 5'd9; s.uses_rt = 1;
        s.ex_valid = 1; s.ex_regwrite = 1; s.ex_dst = 5'd9;
        apply(s, 1'b1);
        apply(nop, 1'b1);

        // Reset asserted in the middle of a memory wait.
        s = nop; s.mem_valid = 1; s.mem_memread = 1; s.mem_dst = 5'd2;
        apply(s, 1'b1);
        apply(s, 1'b1);
        s.id_valid = 1; s.id_rs = 5'd2; s.uses_rs = 1; s.branch = 1; s.taken = 1;
        apply(s, 1'b0);
        apply(s, 1'b0);
        apply(nop, 1'b1);
        apply(nop, 1'b1);

        // Sustained load-use stall drives the counter into saturation.
        s = nop;
        s.id_valid = 1; s.id_rs = 5'd5; s.uses_rs = 1;
        s.ex_valid = 1; s.ex_memread = 1; s.ex_dst = 5'd5;
        repeat (20) apply(s, 1'b1);
        repeat (2) apply(nop, 1'b1);

        repeat (400) apply(rand_stim(), 1'b1);
        apply(nop, 1'b0);
        repeat (100) apply(rand_stim(), 1'b1);

        @(posedge clk);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
